instruction_queue_n: RTL and testbench
======================================

INSTRUCTION_QUEUE_N -- requirements
Module: instruction_queue_n

Interface
REQ-001 Parameter DEPTH, default 8: number of queue entries; the block SHALL accept only powers of two >= 2.
REQ-002 Parameter ADDR_W, default 48: width of the Address field.
REQ-003 Parameter AFULL_LVL, default DEPTH-2: occupancy at which stall_out asserts; valid range is 1..DEPTH.
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 flush  in  1  synchronous discard of all entries.
REQ-007 enq_valid  in  1  instr_in is valid this cycle.
REQ-008 enq_ready  out  1  queue can accept an entry.
REQ-009 instr_in  in  27+ADDR_W  packed entry; fields MSB to LSB: MajorOpcode[4], Source1[5], Source2[5], OffsetScale[2], Destination[5], MinorOpcode[4], HasAddress[1], OffsetSub[1], Address[ADDR_W].
REQ-010 stall_in  in  1  downstream stall; blocks dequeue.
REQ-011 deq_valid  out  1  instr_out holds a valid head entry.
REQ-012 deq_ready  in  1  consumer takes the head entry.
REQ-013 instr_out  out  27+ADDR_W  head entry, same packing as instr_in.
REQ-014 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 stall_out  out  1  upstream stall request (almost full).

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-017 An enqueue SHALL occur when enq_valid && enq_ready; a dequeue SHALL occur when deq_valid && deq_ready.
REQ-018 enq_ready SHALL be !(count == DEPTH), from registered state only, with no combinational path from deq_ready.
REQ-019 deq_valid SHALL be (count != 0) && !stall_in.
REQ-020 instr_out SHALL be the entry at the read pointer (first-word fall-through); it SHALL read all zeros when count == 0.
REQ-021 Enqueue-to-visible latency SHALL be 1 cycle: an entry written at edge N appears on instr_out after edge N if it is the head; there is no same-cycle bypass.
REQ-022 When HasAddress of an accepted entry is 0, the stored Address field SHALL be all zeros regardless of instr_in.
REQ-023 Enqueue and dequeue in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-024 When full, enq_valid SHALL be ignored even if a dequeue occurs that cycle.
REQ-025 When empty, or when stall_in = 1, deq_ready SHALL have no effect.
REQ-026 count SHALL increment by 1 on enqueue only and decrement by 1 on dequeue only; it SHALL never exceed DEPTH or go below 0.
REQ-027 stall_out SHALL be (count >= AFULL_LVL), derived from the registered count.
REQ-028 When flush = 1 at a rising edge, pointers and count SHALL go to 0 and any concurrent enqueue or dequeue SHALL be discarded; flush has priority over both.
REQ-029 Stored entries are not cleared by flush, but instr_out SHALL read zero afterwards per REQ-020.

Reset
REQ-030 While rst_n = 0, the block SHALL immediately, without waiting for clk, clear pointers, count and all entries to 0.
REQ-031 During reset the outputs SHALL be: enq_ready = 1, deq_valid = 0, instr_out = 0, count = 0, stall_out = 0 (for AFULL_LVL >= 1).
REQ-032 Reset asserted mid-operation SHALL discard all entries, including any enqueue in that cycle.
REQ-033 The first enqueue SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-034 Fill/drain, DEPTH=8: enqueue 8 entries with MajorOpcode 0..7 and deq_ready = 0 -> count 8, enq_ready 0, stall_out asserted from count 6; then drain -> MajorOpcode out in order 0..7, then deq_valid 0.
REQ-035 Wrap and simultaneous access: hold count at 3 and do 20 cycles of simultaneous enq/deq -> count stays 3, FIFO order preserved across pointer wrap.
REQ-036 Address normalisation: enqueue HasAddress=0 with Address=98, then HasAddress=1 with Address=98 -> dequeued Address values 0 then 98.
REQ-037 Stall and full: with the queue full, assert stall_in with deq_ready=1 and enq_valid=1 -> no dequeue, no enqueue, deq_valid 0, count 8.
REQ-038 Flush: with count 5, assert flush together with enq_valid and deq_ready -> next cycle count 0, deq_valid 0, instr_out 0.
REQ-039 Asynchronous reset: with count 4, drop rst_n between clock edges -> count, instr_out and stall_out go to 0 before the next edge.

Source files
------------

// File: rtl/instruction_queue_n.sv
// Instruction queue: DEPTH-entry circular FIFO of packed instructions with
// first-word fall-through head, almost-full stall, flush and async reset.
module instruction_queue_n #(
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = 48,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [27+ADDR_W-1:0]       instr_in,
   input  logic                       stall_in,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [27+ADDR_W-1:0]       instr_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       stall_out
);

   localparam int ENTRY_W = 27 + ADDR_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   // Power-of-two depth lets the pointers wrap by plain overflow.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
      $error("instruction_queue_n: DEPTH must be a power of two >= 2");
   end
   if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : gAfullCheck
      $error("instruction_queue_n: AFULL_LVL must be in 1..DEPTH");
   end

   typedef struct packed {
      logic [3:0]        majorOpcode;
      logic [4:0]        source1;
      logic [4:0]        source2;
      logic [1:0]        offsetScale;
      logic [4:0]        destination;
      logic [3:0]        minorOpcode;
      logic              hasAddress;
      logic              offsetSub;
      logic [ADDR_W-1:0] address;
   } entry_t;

   entry_t              mem_q [DEPTH];
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                enqFire;
   logic                deqFire;
   entry_t              enqEntry;
   logic [ENTRY_W-1:0]  headEntry;

   // Entries without an address are stored with a zeroed Address field.
   always_comb begin
      enqEntry = entry_t'(instr_in);
      if (!enqEntry.hasAddress) begin
         enqEntry.address = '0;
      end
   end

   assign enq_ready = (count_q != FULL_CNT);
   assign deq_valid = (count_q != '0) && !stall_in;
   assign enqFire   = enq_valid && enq_ready;
   assign deqFire   = deq_valid && deq_ready;

   assign headEntry = mem_q[rdPtr_q];
   assign instr_out = (count_q == '0) ? '0 : headEntry;
   assign count     = count_q;
   assign stall_out = (count_q >= AFULL_CNT);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (enqFire) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
         end
         if (deqFire) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
         end
         case ({enqFire, deqFire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Flush leaves stored data in place; only the pointers and count reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (enqFire && !flush) begin
         mem_q[wrPtr_q] <= enqEntry;
      end
   end

endmodule

// File: tb/tb_instruction_queue_n.sv
// Randomised and directed bench for instruction_queue_n; a reference queue
// predicts every dequeued entry and the occupancy-derived status outputs.
`timescale 1ns/100ps
module tb_instruction_queue_n;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 48;
   localparam int AFULL  = DEPTH - 2;
   localparam int W      = 27 + ADDR_W;
   localparam int CW     = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          enq_valid;
   logic          enq_ready;
   logic [W-1:0]  instr_in;
   logic          stall_in;
   logic          deq_valid;
   logic          deq_ready;
   logic [W-1:0]  instr_out;
   logic [CW-1:0] count;
   logic          stall_out;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  sbq[$];
   int            modelCount = 0;
   logic [W-1:0]  monExp;

   instruction_queue_n #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .AFULL_LVL(AFULL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .enq_valid(enq_valid),
      .enq_ready(enq_ready),
      .instr_in (instr_in),
      .stall_in (stall_in),
      .deq_valid(deq_valid),
      .deq_ready(deq_ready),
      .instr_out(instr_out),
      .count    (count),
      .stall_out(stall_out)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [W-1:0] randInstr();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] makeInstr(input int major, input logic hasAddr,
                                              input logic [ADDR_W-1:0] addr);
      logic [W-1:0] v;
      v = randInstr();
      v[W-1 -: 4]   = 4'(major);
      v[ADDR_W+1]   = hasAddr;
      v[ADDR_W-1:0] = addr;
      return v;
   endfunction

   // Stored form of an instruction: Address is zero unless HasAddress is set.
   function automatic logic [W-1:0] expectedEntry(input logic [W-1:0] v);
      logic [W-1:0] e;
      e = v;
      if (!e[ADDR_W+1]) begin
         e[ADDR_W-1:0] = '0;
      end
      return e;
   endfunction

   // Called just after a rising edge: drive one cycle, check, advance model.
   task automatic applyStimulus(input logic ev, input logic [W-1:0] data,
                                input logic dr, input logic st, input logic fl);
      logic enqOk;
      logic deqOk;
      enq_valid = ev;
      instr_in  = data;
      deq_ready = dr;
      stall_in  = st;
      flush     = fl;
      #1;
      checkOutput("count", W'(count), W'(modelCount));
      checkOutput("enq_ready", W'(enq_ready), W'(modelCount != DEPTH));
      checkOutput("deq_valid", W'(deq_valid), W'((modelCount != 0) && !st));
      checkOutput("stall_out", W'(stall_out), W'(modelCount >= AFULL));
      if (modelCount == 0) begin
         checkOutput("instr_out_empty", instr_out, '0);
      end else if (sbq.size() > 0) begin
         checkOutput("instr_out_head", instr_out, sbq[0]);
      end else begin
         checkOutput("scoreboard_level", W'(sbq.size()), W'(modelCount));
      end
      enqOk = ev && (modelCount != DEPTH) && !fl;
      deqOk = dr && !st && (modelCount != 0) && !fl;
      if (fl) begin
         sbq.delete();
         modelCount = 0;
      end else begin
         if (enqOk) begin
            sbq.push_back(expectedEntry(data));
         end
         modelCount = modelCount + int'(enqOk) - int'(deqOk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic asyncReset();
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      stall_in  = 1'b0;
      flush     = 1'b0;
      #2;
      rst_n = 1'b0;
      #0.5;
      checkOutput("areset_count", W'(count), '0);
      checkOutput("areset_instr_out", instr_out, '0);
      checkOutput("areset_stall_out", W'(stall_out), '0);
      checkOutput("areset_enq_ready", W'(enq_ready), W'(1));
      checkOutput("areset_deq_valid", W'(deq_valid), '0);
      sbq.delete();
      modelCount = 0;
      #0.5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake that the DUT completes must match the queue head.
   always @(negedge clk) begin
      if (rst_n && deq_valid && deq_ready && !flush) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dequeue_underflow: got %h, expected no dequeue", instr_out);
         end else begin
            monExp = sbq.pop_front();
            checkOutput("dequeue", instr_out, monExp);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      enq_valid = 1'b1;
      instr_in  = randInstr();
      deq_ready = 1'b1;
      stall_in  = 1'b0;
      #12;
      checkOutput("reset_count", W'(count), '0);
      checkOutput("reset_enq_ready", W'(enq_ready), W'(1));
      checkOutput("reset_deq_valid", W'(deq_valid), '0);
      checkOutput("reset_instr_out", instr_out, '0);
      checkOutput("reset_stall_out", W'(stall_out), '0);
      rst_n = 1'b1;

      $display("[TB] fill and drain");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, makeInstr(i, 1'b1, ADDR_W'($urandom())), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, makeInstr(15, 1'b1, '0), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, makeInstr(14, 1'b1, '0), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) begin
         applyStimulus(1'b0, randInstr(), 1'b1, 1'b0, 1'b0);
      end

      $display("[TB] wrap with simultaneous access");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, randInstr(), 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, randInstr(), 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, randInstr(), 1'b1, 1'b0, 1'b0);
      end

      $display("[TB] address normalisation");
      applyStimulus(1'b1, makeInstr(3, 1'b0, ADDR_W'(98)), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, makeInstr(4, 1'b1, ADDR_W'(98)), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, randInstr(), 1'b1, 1'b0, 1'b0);
      end

      $display("[TB] stall while full");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, randInstr(), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, randInstr(), 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, randInstr(), 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) begin
         applyStimulus(1'b0, randInstr(), 1'b1, 1'b0, 1'b0);
      end

      $display("[TB] flush");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, randInstr(), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, randInstr(), 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, randInstr(), 1'b1, 1'b0, 1'b0);

      $display("[TB] asynchronous reset");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, randInstr(), 1'b0, 1'b0, 1'b0);
      end
      asyncReset();
      applyStimulus(1'b1, randInstr(), 1'b0, 1'b0, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60), randInstr(),
                       1'($urandom_range(0, 99) < 50),
                       1'($urandom_range(0, 99) < 20),
                       1'($urandom_range(0, 99) < 3));
      end
      for (int i = 0; i < DEPTH + 2; i++) begin
         applyStimulus(1'b0, randInstr(), 1'b1, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
